// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and sizing helpers for the matrix-multiplier datapath
package matmul_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // Smallest accumulator that cannot wrap for a full vector of maximum products.
  function automatic int min_acc_width(input int data_width, input int vec_len);
    return 2 * data_width + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/vedicmultiplier_8bit.sv
// rtl/vedicmultiplier_8bit.sv - unsigned 8x8 Urdhva-Tiryagbhyam multiplier built from 2x2 cells
module vedicmultiplier_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic t0, t1, t2;
    t0 = x[1] & y[0];
    t1 = x[0] & y[1];
    t2 = x[1] & y[1];
    return {t2 & t0 & t1, t2 ^ (t0 & t1), t0 ^ t1, x[0] & y[0]};
  endfunction

  // Each level splits both operands in half and recombines the four vertical/crosswise partials.
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, hl, lh, hh;
    ll = mul2(x[1:0], y[1:0]);
    hl = mul2(x[3:2], y[1:0]);
    lh = mul2(x[1:0], y[3:2]);
    hh = mul2(x[3:2], y[3:2]);
    return {4'b0, ll} + {2'b0, hl, 2'b0} + {2'b0, lh, 2'b0} + {hh, 4'b0};
  endfunction

  function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ll, hl, lh, hh;
    ll = mul4(x[3:0], y[3:0]);
    hl = mul4(x[7:4], y[3:0]);
    lh = mul4(x[3:0], y[7:4]);
    hh = mul4(x[7:4], y[7:4]);
    return {8'b0, ll} + {4'b0, hl, 4'b0} + {4'b0, lh, 4'b0} + {hh, 8'b0};
  endfunction

  assign p = mul8(a, b);

endmodule

// File: rtl/vedic_mac_accumulator.sv
// rtl/vedic_mac_accumulator.sv - dot-product accumulator behind the Vedic multiplier, valid/ready in and out
module vedic_mac_accumulator
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VEC_LEN    = 4,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData_A,
  input  logic [DATA_WIDTH-1:0] inData_B,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ACC_WIDTH-1:0]  outData_C,
  output logic                  busy
);

  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q;
  logic                      prod_valid_q;
  logic                      prod_first_q;
  logic [2*DATA_WIDTH-1:0]   prod_q;
  logic [2*DATA_WIDTH-1:0]   prod_w;
  logic [ACC_WIDTH-1:0]      acc_q;
  logic                      accept;
  logic                      last_beat;

  vedicmultiplier_8bit u_mul (
    .a (inData_A),
    .b (inData_B),
    .p (prod_w)
  );

  assign accept    = inValid && (state_q == S_ACC);
  assign last_beat = (cnt_q == CW'(VEC_LEN - 1));
  assign busy      = (cnt_q != '0) || (state_q != S_ACC);

  always_comb begin
    state_d   = state_q;
    inReady   = 1'b0;
    outValid  = 1'b0;
    outData_C = '0;
    case (state_q)
      S_ACC: begin
        inReady = 1'b1;
        if (accept && last_beat) state_d = S_FLUSH;
      end
      // The final product is still in prod_q here; it lands in acc_q on this edge.
      S_FLUSH: state_d = S_OUT;
      S_OUT: begin
        outValid  = 1'b1;
        outData_C = acc_q;
        if (outReady) state_d = S_ACC;
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ACC;
      cnt_q        <= '0;
      prod_valid_q <= 1'b0;
      prod_first_q <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      prod_valid_q <= accept;
      if (accept) begin
        prod_q       <= prod_w;
        prod_first_q <= (cnt_q == '0);
        cnt_q        <= last_beat ? '0 : cnt_q + 1'b1;
      end
      // Loading on the first product clears the previous vector's sum without a separate clear cycle.
      if (prod_valid_q) begin
        acc_q <= prod_first_q ? ACC_WIDTH'(prod_q) : acc_q + ACC_WIDTH'(prod_q);
      end
    end
  end

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// tb/tb_vedic_mac_accumulator.sv - scoreboard bench for vedic_mac_accumulator
module tb_vedic_mac_accumulator;

  localparam int DW = 8;
  localparam int VL = 4;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData_A;
  logic [DW-1:0] inData_B;
  logic          outValid;
  logic          outReady;
  logic [AW-1:0] outData_C;
  logic          busy;

  int checks = 0;
  int errors = 0;
  longint expq[$];
  int  negcnt = 0;
  int  last_acc_neg = 0;
  bit  lat_armed = 0;
  bit  prev_ov = 0;
  bit  prev_hold = 0;
  logic [AW-1:0] prev_data = '0;
  bit  stop_rand = 0;

  always #5 clk = ~clk;

  vedic_mac_accumulator #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .inValid   (inValid),
    .inReady   (inReady),
    .inData_A  (inData_A),
    .inData_B  (inData_B),
    .outValid  (outValid),
    .outReady  (outReady),
    .outData_C (outData_C),
    .busy      (busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake, and watches latency and hold stability.
  always @(negedge clk) begin
    negcnt++;
    if (rst) begin
      prev_ov   = 0;
      prev_hold = 0;
    end else begin
      if (outValid && !prev_ov && lat_armed) begin
        chk("latency_negedges", negcnt - last_acc_neg, 2);
        lat_armed = 0;
      end
      if (prev_hold && outValid) chk("hold_stable", outData_C, prev_data);
      if (outValid && outReady) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d, expected no output", outData_C);
        end else begin
          chk("result", outData_C, expq.pop_front());
        end
      end
      prev_hold = outValid && !outReady;
      prev_data = outData_C;
      prev_ov   = outValid;
    end
  end

  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int t = 0;
    inValid  = 1'b1;
    inData_A = a;
    inData_B = b;
    @(negedge clk);
    while (!inReady && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!inReady) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got inReady=0 for %0d cycles, expected 1", t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_vector(input logic [DW-1:0] va[VL], input logic [DW-1:0] vb[VL], input bit gaps);
    longint dot = 0;
    for (int i = 0; i < VL; i++) begin
      send_beat(va[i], vb[i]);
      dot += longint'(va[i]) * longint'(vb[i]);
      if (i == VL - 1) begin
        last_acc_neg = negcnt;
        lat_armed    = 1;
        expq.push_back(dot % (64'd1 << AW));
      end
      if (gaps && i != VL - 1) begin
        inValid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    inValid = 1'b0;
  endtask

  logic [DW-1:0] va[VL];
  logic [DW-1:0] vb[VL];

  initial begin
    rst = 1'b1; inValid = 1'b0; inData_A = '0; inData_B = '0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_inReady", inReady, 1);
    chk("reset_outValid", outValid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_outData_C", outData_C, 0);
    @(posedge clk); #1;

    // Basic dot product, inValid held high.
    va = '{8'd1, 8'd2, 8'd3, 8'd4}; vb = '{8'd5, 8'd6, 8'd7, 8'd8};
    send_vector(va, vb, 0);
    @(negedge clk); chk("basic_inReady_flush", inReady, 0);
    @(negedge clk); chk("basic_inReady_out", inReady, 0);
    chk("basic_outData_C", outData_C, 70);
    @(negedge clk); chk("basic_inReady_back", inReady, 1);
    @(posedge clk); #1;

    // Maximum operands.
    va = '{8'd255, 8'd255, 8'd255, 8'd255}; vb = va;
    send_vector(va, vb, 0);
    repeat (3) @(posedge clk); #1;

    // Output backpressure with the next beat waiting.
    outReady = 1'b0;
    va = '{8'd3, 8'd5, 8'd7, 8'd11}; vb = '{8'd13, 8'd17, 8'd19, 8'd23};
    send_vector(va, vb, 0);
    inValid = 1'b1; inData_A = 8'd6; inData_B = 8'd7;
    begin
      int t = 0;
      @(negedge clk);
      while (!outValid && t < 20) begin t++; @(negedge clk); end
      chk("bp_outValid_seen", outValid, 1);
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_inReady", inReady, 0);
      chk("bp_busy", busy, 1);
      chk("bp_outValid", outValid, 1);
    end
    @(posedge clk); #1 outReady = 1'b1;
    va = '{8'd6, 8'd1, 8'd2, 8'd3}; vb = '{8'd7, 8'd4, 8'd5, 8'd6};
    send_vector(va, vb, 0);

    // Gapped input.
    va = '{8'd2, 8'd2, 8'd2, 8'd2}; vb = '{8'd3, 8'd3, 8'd3, 8'd3};
    send_vector(va, vb, 1);

    // Reset mid-vector discards the partial sum.
    send_beat(8'd9, 8'd9);
    send_beat(8'd9, 8'd9);
    inValid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_outValid", outValid, 0);
    @(posedge clk); #1;
    va = '{8'd10, 8'd10, 8'd10, 8'd10}; vb = va;
    send_vector(va, vb, 0);

    // Back-to-back vectors.
    va = '{8'd1, 8'd1, 8'd1, 8'd1}; vb = va;
    send_vector(va, vb, 0);
    va = '{8'd0, 8'd0, 8'd0, 8'd0}; vb = '{8'd200, 8'd200, 8'd200, 8'd200};
    send_vector(va, vb, 0);

    // Randomized vectors with random gaps and random backpressure.
    fork
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          outReady = ($urandom_range(0, 3) != 0);
        end
        outReady = 1'b1;
      end
    join_none
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < VL; i++) begin
        va[i] = DW'($urandom);
        vb[i] = DW'($urandom);
      end
      send_vector(va, vb, $urandom_range(0, 1) == 1);
    end
    stop_rand = 1;

    begin
      int t = 0;
      while (expq.size() != 0 && t < 300) begin t++; @(posedge clk); end
    end
    #1;
    chk("drain_queue_empty", expq.size(), 0);
    @(negedge clk);
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vedic_mac_accumulator.md
Name: vedic_mac_accumulator

Overview:
Dot-product stage that sits directly downstream of the 8-bit Vedic multiplier in the matrix-multiplier datapath. It accepts a stream of operand pairs (one row element and one column element per beat) over a valid/ready handshake. Each pair goes through an instance of vedicmultiplier_8bit, and the block accumulates VEC_LEN products into one matrix-cell result. The finished result is presented on a valid/ready output channel to the result-collection logic.

Parameters:
DATA_WIDTH, 8, operand width; fixed at 8 because the multiplier is 8-bit; any other value is illegal.
VEC_LEN, 4, products per result (dot-product length); legal range 2..256.
ACC_WIDTH, 18, accumulator/result width; must be >= 2*DATA_WIDTH + clog2(VEC_LEN).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
inValid  input  1  operand pair valid
inReady  output  1  block can accept an operand pair
inData_A  input  DATA_WIDTH  row operand, unsigned
inData_B  input  DATA_WIDTH  column operand, unsigned
outValid  output  1  outData_C holds a completed dot product
outReady  input  1  downstream accepts the result
outData_C  output  ACC_WIDTH  accumulated dot product, unsigned
busy  output  1  high while a partial sum is in progress or a result is pending

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high.
- Reset state:
  - state=S_ACC, beat counter=0, prod_valid=0, product register=0, accumulator=0.
  - outValid=0, outData_C=0, busy=0.
  - inReady is combinational (state==S_ACC), so it reads 1 in the cycle after reset is released.
- Reset mid-operation: any partial sum or pending result is discarded with no output.
- Beat acceptance:
  - A beat is accepted on a rising edge where inValid && inReady.
  - inData_A and inData_B feed vedicmultiplier_8bit combinationally.
  - The 16-bit product is registered on the same edge and prod_valid is set.
- Accumulate:
  - On the edge after prod_valid, the accumulator loads the zero-extended product if it is the first product of the vector; otherwise it adds the product.
  - Unused prod_valid cycles leave the accumulator unchanged.
- FSM:
  - S_ACC: inReady=1.
    - On acceptance with counter<VEC_LEN-1: counter increments.
    - On acceptance with counter==VEC_LEN-1: counter goes to 0 and state goes to S_FLUSH.
    - Gaps in inValid are allowed; the counter and accumulator hold.
  - S_FLUSH: inReady=0. The last product is added to the accumulator, then state goes to S_OUT.
  - S_OUT: inReady=0, outValid=1, outData_C=accumulator.
    - outData_C is stable while outReady=0.
    - On outValid && outReady: state goes to S_ACC and outValid drops the next cycle.
- Latency: outValid rises 2 clock edges after the edge that accepts the last beat.
- Minimum period per result: VEC_LEN+2 cycles when outReady is held high.
- busy: 1 when the counter is non-zero or the state is not S_ACC.
- Arithmetic:
  - Unsigned, modulo 2^ACC_WIDTH.
  - With legal parameters the result cannot overflow (max for defaults = 260100 = 0x3F804).
- Input while not ready: inValid asserted while inReady=0 is ignored; upstream must hold its data.

Decomposition:
- Shared package (matmul_pkg):
  - state encoding constants S_ACC/S_FLUSH/S_OUT.
  - constant function for the minimum ACC_WIDTH (2*DATA_WIDTH+clog2(VEC_LEN)).
  - DATA_WIDTH default constant.
- One sub-module: the existing vedicmultiplier_8bit, instantiated once.
- The FSM, counter and accumulator stay in this module.

Test Plan:
- Basic dot product: after reset, send A={1,2,3,4}, B={5,6,7,8} with inValid held high and outReady=1. Required: outData_C=70 with outValid high exactly 2 edges after the 4th beat; inReady low for 2 cycles, then high again.
- Maximum operands: four beats of A=255, B=255. Required: outData_C=260100 (0x3F804), no wrap.
- Output backpressure: outReady=0 for 5 cycles after outValid rises, with inValid held high. Required: outData_C held constant, inReady=0, no beat consumed; result and handshake complete when outReady=1.
- Gapped input: toggle inValid 1/0 with A={2,2,2,2}, B={3,3,3,3}. Required: outData_C=24, no products lost or double-counted.
- Reset mid-vector: accept 2 beats of {9,9}, pulse rst for 1 cycle, then send A={10,10,10,10}, B={10,10,10,10}. Required: no output for the aborted vector, then outData_C=400.
- Back-to-back vectors: send {1,1,1,1}x{1,1,1,1} followed immediately by {0,0,0,0}x{200,…}, outReady=1. Required: results 4 then 0; the second vector starts the cycle after S_OUT completes (first-product load clears the old sum).
